// File: rtl/playback_sequencer.sv
// Song playback sequencer: drives the card loader and header parser, gates the SMP/DSP,
// keeps elapsed play time and steps through songs on buttons, song end or load failure.
module playback_sequencer #(
    parameter int TICKS_PER_SEC = 24469000,
    parameter int DEBOUNCE      = 250000,
    parameter int MAX_FAIL      = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic [15:0] total,
    input  logic [15:0] length,
    output logic        loader_start,
    input  logic        loader_done,
    input  logic        loader_fail,
    output logic        parser_start,
    input  logic        parser_done,
    output logic        spc_reset,
    output logic        spc_ready,
    output logic [15:0] song,
    output logic [5:0]  minute,
    output logic [5:0]  second,
    output logic [15:0] played,
    output logic        halted,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_LOAD  = 3'd1,
        S_PARSE = 3'd2,
        S_PLAY  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);

    state_t          state_q;
    logic [15:0]     song_q;
    logic [FW-1:0]   fail_cnt_q;
    logic            loader_start_q;
    logic            parser_start_q;
    logic            spc_reset_q;
    logic            spc_ready_q;
    logic            halted_q;

    logic [PW-1:0]   pre_q;
    logic [15:0]     played_q;
    logic [5:0]      minute_q;
    logic [5:0]      second_q;

    // Index 0 is next, index 1 is prev.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      level_q;
    logic [1:0]      press_q;
    logic [DW-1:0]   db_cnt_q [2];

    logic [15:0]     song_next_d;
    logic [15:0]     song_prev_d;
    logic [FW-1:0]   fail_inc_d;
    logic            next_acc;
    logic            prev_acc;
    logic            song_end;
    logic            enter_play;

    assign btn_raw = {btn_prev, btn_next};

    // A level change is accepted only after it has held for DEBOUNCE cycles; a press is its 0->1 acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            level_q <= 2'b00;
            press_q <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] == DB_MAX) begin
                        level_q[i]  <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                        press_q[i]  <= sync2_q[i];
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        song_next_d = 16'd0;
        if (total > 16'd1 && song_q < total - 16'd1) song_next_d = song_q + 16'd1;
    end

    always_comb begin
        song_prev_d = 16'd0;
        if (total > 16'd1) begin
            if (song_q == 16'd0 || song_q > total - 16'd1) song_prev_d = total - 16'd1;
            else song_prev_d = song_q - 16'd1;
        end
    end

    // Presses count only in PLAY once a second has elapsed, so a bounce across a song change is dropped.
    assign next_acc   = press_q[0] && (played_q != 16'd0);
    assign prev_acc   = press_q[1] && (played_q != 16'd0);
    assign song_end   = (length != 16'd0) && (played_q >= length);
    assign fail_inc_d = fail_cnt_q + 1'b1;
    assign enter_play = (state_q == S_PARSE) && parser_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q    <= '0;
            played_q <= 16'd0;
            minute_q <= 6'd0;
            second_q <= 6'd0;
        end else if (enter_play) begin
            pre_q    <= '0;
            played_q <= 16'd0;
            minute_q <= 6'd0;
            second_q <= 6'd0;
        end else if (state_q == S_PLAY) begin
            if (pre_q == PRE_MAX) begin
                pre_q <= '0;
                if (played_q != 16'hFFFF) played_q <= played_q + 16'd1;
                if (second_q == 6'd59) begin
                    second_q <= 6'd0;
                    minute_q <= minute_q + 6'd1;
                end else begin
                    second_q <= second_q + 6'd1;
                end
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    // Start/done handshake: a start is a one-cycle pulse issued only from the state that then waits
    // for that unit's done/fail pulse, so no start can reach a unit that is still busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_INIT;
            song_q         <= 16'd0;
            fail_cnt_q     <= '0;
            loader_start_q <= 1'b0;
            parser_start_q <= 1'b0;
            spc_reset_q    <= 1'b1;
            spc_ready_q    <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            loader_start_q <= 1'b0;
            parser_start_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    spc_reset_q    <= 1'b0;
                    spc_ready_q    <= 1'b0;
                    loader_start_q <= 1'b1;
                    state_q        <= S_LOAD;
                end
                S_LOAD: begin
                    if (loader_fail) begin
                        song_q      <= song_next_d;
                        fail_cnt_q  <= fail_inc_d;
                        spc_reset_q <= 1'b1;
                        if (fail_inc_d >= FAIL_LIMIT) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            state_q  <= S_INIT;
                        end
                    end else if (loader_done) begin
                        parser_start_q <= 1'b1;
                        fail_cnt_q     <= '0;
                        state_q        <= S_PARSE;
                    end
                end
                S_PARSE: begin
                    if (parser_done) begin
                        spc_ready_q <= 1'b1;
                        state_q     <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (next_acc || song_end) begin
                        song_q      <= song_next_d;
                        spc_ready_q <= 1'b0;
                        spc_reset_q <= 1'b1;
                        state_q     <= S_INIT;
                    end else if (prev_acc) begin
                        song_q      <= song_prev_d;
                        spc_ready_q <= 1'b0;
                        spc_reset_q <= 1'b1;
                        state_q     <= S_INIT;
                    end
                end
                S_HALT: begin
                    spc_reset_q <= 1'b1;
                    spc_ready_q <= 1'b0;
                    halted_q    <= 1'b1;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign loader_start = loader_start_q;
    assign parser_start = parser_start_q;
    assign spc_reset    = spc_reset_q;
    assign spc_ready    = spc_ready_q;
    assign song         = song_q;
    assign minute       = minute_q;
    assign second       = second_q;
    assign played       = played_q;
    assign halted       = halted_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer with short timing parameters; expected song indices are queued
// when a song change is provoked and compared whenever the sequencer issues loader_start.
module tb_playback_sequencer;
  localparam int TPS = 10;
  localparam int DB  = 4;
  localparam int MF  = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        btn_next, btn_prev;
  logic [15:0] total, length;
  logic        loader_start, loader_done, loader_fail;
  logic        parser_start, parser_done;
  logic        spc_reset, spc_ready, halted;
  logic [15:0] song, played;
  logic [5:0]  minute, second;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int ls_cnt = 0;
  int ps_cnt = 0;
  logic ls_prev = 1'b0;
  logic [15:0] exp_q[$];

  playback_sequencer #(.TICKS_PER_SEC(TPS), .DEBOUNCE(DB), .MAX_FAIL(MF)) dut (
    .clk(clk), .resetn(resetn), .btn_next(btn_next), .btn_prev(btn_prev),
    .total(total), .length(length), .loader_start(loader_start),
    .loader_done(loader_done), .loader_fail(loader_fail),
    .parser_start(parser_start), .parser_done(parser_done),
    .spc_reset(spc_reset), .spc_ready(spc_ready), .song(song),
    .minute(minute), .second(second), .played(played), .halted(halted),
    .state_o(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every loader_start must match the next queued song index.
  always @(negedge clk) begin
    if (ls_prev) check_val("ls_one_cycle", {31'd0, loader_start}, 32'd0);
    if (loader_start) begin
      ls_cnt++;
      check_val("ls_pending", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check_val("load_song", {16'd0, song}, {16'd0, exp_q.pop_front()});
    end
    if (parser_start) ps_cnt++;
    ls_prev = loader_start;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ls(input int bound);
    int s;
    int k;
    s = ls_cnt;
    k = 0;
    while (ls_cnt == s && k < bound) begin
      step();
      k++;
    end
    check_val("ls_seen", ls_cnt - s, 32'd1);
  endtask

  task automatic finish_load();
    int s;
    int k;
    s = ps_cnt;
    loader_done = 1'b1;
    step();
    loader_done = 1'b0;
    k = 0;
    while (ps_cnt == s && k < 10) begin
      step();
      k++;
    end
    check_val("ps_seen", ps_cnt - s, 32'd1);
    check_val("ready_before", {31'd0, spc_ready}, 32'd0);
    parser_done = 1'b1;
    step();
    parser_done = 1'b0;
    check_val("ready_after", {31'd0, spc_ready}, 32'd1);
  endtask

  task automatic load_ok(input int bound);
    wait_ls(bound);
    finish_load();
  endtask

  task automatic wait_ready_fall(input int bound);
    int k;
    k = 0;
    while (spc_ready && k < bound) begin
      step();
      k++;
    end
    check_val("ready_fall", {31'd0, spc_ready}, 32'd0);
  endtask

  task automatic wait_played(input int n, input int bound);
    int k;
    k = 0;
    while (played < n && k < bound) begin
      step();
      k++;
    end
    check_val("played_reach", {31'd0, played >= n}, 32'd1);
  endtask

  task automatic fail_pulse(input logic with_done);
    loader_fail = 1'b1;
    loader_done = with_done;
    step();
    loader_fail = 1'b0;
    loader_done = 1'b0;
  endtask

  initial begin
    int s;
    int sp;
    resetn = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    total = 16'd5; length = 16'd0;
    loader_done = 1'b0; loader_fail = 1'b0; parser_done = 1'b0;
    repeat (3) step();
    check_val("rst_spc_reset", {31'd0, spc_reset}, 32'd1);
    check_val("rst_spc_ready", {31'd0, spc_ready}, 32'd0);
    check_val("rst_ls", {31'd0, loader_start}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_song", {16'd0, song}, 32'd0);
    check_val("rst_played", {16'd0, played}, 32'd0);

    // First load after reset release, with ready the cycle after parser_done.
    exp_q.push_back(16'd0);
    resetn = 1'b1;
    load_ok(2);
    check_val("one_ls", ls_cnt, 32'd1);
    check_val("one_ps", ps_cnt, 32'd1);

    // prev from song 0 wraps to total-1.
    wait_played(1, 20);
    exp_q.push_back(16'd4);
    btn_prev = 1'b1;
    wait_ready_fall(40);
    check_val("prev_wrap", {16'd0, song}, 32'd4);
    btn_prev = 1'b0;
    length = 16'd3;
    load_ok(50);

    // Song end at length=3 from song 4 wraps to 0.
    exp_q.push_back(16'd0);
    wait_ready_fall(60);
    check_val("auto_played", {16'd0, played}, 32'd3);
    check_val("auto_wrap", {16'd0, song}, 32'd0);
    length = 16'd0;
    load_ok(50);

    // A press landing while played==0 is dropped.
    s = ls_cnt;
    btn_next = 1'b1;
    repeat (12) step();
    btn_next = 1'b0;
    repeat (10) step();
    check_val("guard_ready", {31'd0, spc_ready}, 32'd1);
    check_val("guard_song", {16'd0, song}, 32'd0);
    check_val("guard_no_ls", ls_cnt - s, 32'd0);

    // Bouncing then a long hold gives exactly one advance.
    wait_played(1, 20);
    exp_q.push_back(16'd1);
    s = ls_cnt;
    for (int i = 0; i < 3; i++) begin
      btn_next = 1'b1;
      repeat (2) step();
      btn_next = 1'b0;
      repeat (2) step();
    end
    check_val("bounce_no_early", {31'd0, spc_ready}, 32'd1);
    btn_next = 1'b1;
    repeat (20) step();
    btn_next = 1'b0;
    check_val("one_advance", ls_cnt - s, 32'd1);
    check_val("bounce_song", {16'd0, song}, 32'd1);
    finish_load();
    s = ls_cnt;
    repeat (15) step();
    check_val("no_second_adv", ls_cnt - s, 32'd0);

    // next and prev accepted together: next wins.
    wait_played(1, 20);
    exp_q.push_back(16'd2);
    btn_next = 1'b1;
    btn_prev = 1'b1;
    wait_ready_fall(40);
    check_val("next_wins", {16'd0, song}, 32'd2);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    load_ok(50);

    // One hour at length=0: no auto-advance, minute/second roll correctly.
    s = ls_cnt;
    wait_played(3600, 37000);
    check_val("hour_minute", {26'd0, minute}, 32'd60);
    check_val("hour_second", {26'd0, second}, 32'd0);
    check_val("hour_played", {16'd0, played}, 32'd3600);
    check_val("hour_ready", {31'd0, spc_ready}, 32'd1);
    check_val("hour_no_ls", ls_cnt - s, 32'd0);

    // Reset mid-PLAY aborts immediately.
    resetn = 1'b0;
    #1;
    check_val("rplay_ready", {31'd0, spc_ready}, 32'd0);
    check_val("rplay_reset", {31'd0, spc_reset}, 32'd1);
    check_val("rplay_song", {16'd0, song}, 32'd0);
    check_val("rplay_played", {16'd0, played}, 32'd0);
    repeat (3) step();

    // Three consecutive failures (the last with done in the same cycle) halt.
    exp_q.push_back(16'd0);
    resetn = 1'b1;
    wait_ls(5);
    exp_q.push_back(16'd1);
    fail_pulse(1'b0);
    wait_ls(5);
    exp_q.push_back(16'd2);
    fail_pulse(1'b0);
    wait_ls(5);
    s = ls_cnt;
    sp = ps_cnt;
    fail_pulse(1'b1);
    repeat (20) step();
    check_val("halt_flag", {31'd0, halted}, 32'd1);
    check_val("halt_spc_reset", {31'd0, spc_reset}, 32'd1);
    check_val("halt_spc_ready", {31'd0, spc_ready}, 32'd0);
    check_val("halt_no_ls", ls_cnt - s, 32'd0);
    check_val("halt_no_ps", ps_cnt - sp, 32'd0);

    resetn = 1'b0;
    #1;
    check_val("rhalt_cleared", {31'd0, halted}, 32'd0);
    repeat (2) step();

    // Reset mid-LOAD with song 1 pending.
    exp_q.push_back(16'd0);
    resetn = 1'b1;
    wait_ls(5);
    exp_q.push_back(16'd1);
    fail_pulse(1'b0);
    wait_ls(5);
    resetn = 1'b0;
    #1;
    check_val("rload_song", {16'd0, song}, 32'd0);
    check_val("rload_spc_reset", {31'd0, spc_reset}, 32'd1);
    s = ls_cnt;
    repeat (5) step();
    check_val("rload_no_ls", ls_cnt - s, 32'd0);
    exp_q.push_back(16'd0);
    resetn = 1'b1;
    load_ok(5);

    check_val("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
